// File: rtl/lap_recorder.sv
// Circular lap/split store: captures BCD time on split pulses and lets the display
// browse stored laps oldest-to-newest before returning to live time.
module lap_recorder #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       time_i,
  input  logic              capture_i,
  input  logic              recall_i,
  input  logic              clear_i,
  output logic [31:0]       time_o,
  output logic              browse_o,
  output logic [IDX_W:0]    lap_idx_o,
  output logic [IDX_W:0]    count_o,
  output logic              full_o,
  output logic              overflow_o
);

  typedef enum logic {LIVE, BROWSE} state_t;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]     count_q, count_d, idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        time_q, time_d;
  logic [31:0]        mem_q [DEPTH];
  logic               full, forced_live, wr_en;

  assign full  = (count_q == FULL_CNT);
  assign wr_en = capture_i && !clear_i;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    forced_live = 1'b0;
    time_d      = (state_q == BROWSE) ? mem_q[rd_ptr_q] : time_i;

    if (clear_i) begin
      state_d  = LIVE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (capture_i) begin
        wr_ptr_d = wr_ptr_q + IDX_W'(1);
        if (full) begin
          ovf_d = 1'b1;
          // Overwriting the oldest lap renumbers the sequence; drop any open view.
          if (state_q == BROWSE) begin
            state_d     = LIVE;
            idx_d       = '0;
            forced_live = 1'b1;
          end
        end else begin
          count_d = count_q + (IDX_W+1)'(1);
        end
      end

      if (recall_i && !forced_live) begin
        unique case (state_q)
          LIVE: begin
            if (count_d != '0) begin
              state_d  = BROWSE;
              rd_ptr_d = wr_ptr_d - count_d[IDX_W-1:0];
              idx_d    = (IDX_W+1)'(1);
            end
          end
          BROWSE: begin
            if (idx_q < count_d) begin
              rd_ptr_d = rd_ptr_q + IDX_W'(1);
              idx_d    = idx_q + (IDX_W+1)'(1);
            end else begin
              state_d = LIVE;
              idx_d   = '0;
            end
          end
          default: state_d = LIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LIVE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      time_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      time_q   <= time_d;
    end
  end

  // Lap storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= time_i;
  end

  assign time_o     = time_q;
  assign browse_o   = (state_q == BROWSE);
  assign lap_idx_o  = idx_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: a queue-of-laps reference model predicts every
// cycle's outputs; a monitor pops and compares one expectation after each clock edge.
module tb_lap_recorder;

  localparam int DEPTH = 8;
  localparam int IDX_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      time_i = '0;
  logic             capture_i = 1'b0, recall_i = 1'b0, clear_i = 1'b0;
  logic [31:0]      time_o;
  logic             browse_o, full_o, overflow_o;
  logic [IDX_W:0]   lap_idx_o, count_o;

  lap_recorder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .time_i(time_i), .capture_i(capture_i),
    .recall_i(recall_i), .clear_i(clear_i), .time_o(time_o),
    .browse_o(browse_o), .lap_idx_o(lap_idx_o), .count_o(count_o),
    .full_o(full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] t;
    bit          br;
    int          idx;
    int          cnt;
    bit          full;
    bit          ovf;
  } exp_t;

  exp_t         exq[$];
  int           vectors = 0;
  int           miscompares = 0;

  // Reference model: laps held oldest-first; m_idx is the 1-based lap shown.
  logic [31:0]  laps[$];
  bit           m_br = 1'b0;
  int           m_idx = 0;
  bit           m_ovf = 1'b0;

  task automatic model_reset();
    laps.delete();
    m_br = 1'b0; m_idx = 0; m_ovf = 1'b0;
  endtask

  task automatic step(input bit cap, input bit rec, input bit clr, input logic [31:0] t);
    exp_t e;
    bit   forced;
    @(negedge clk);
    capture_i = cap; recall_i = rec; clear_i = clr; time_i = t;
    e.t = m_br ? laps[m_idx-1] : t;
    forced = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (cap) begin
        if (laps.size() == DEPTH) begin
          void'(laps.pop_front());
          m_ovf = 1'b1;
          if (m_br) begin m_br = 1'b0; m_idx = 0; forced = 1'b1; end
        end
        laps.push_back(t);
      end
      if (rec && !forced) begin
        if (!m_br) begin
          if (laps.size() > 0) begin m_br = 1'b1; m_idx = 1; end
        end else if (m_idx < laps.size()) begin
          m_idx++;
        end else begin
          m_br = 1'b0; m_idx = 0;
        end
      end
    end
    e.br = m_br; e.idx = m_idx; e.cnt = laps.size();
    e.full = (laps.size() == DEPTH); e.ovf = m_ovf;
    exq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (time_o !== 32'h0 || browse_o !== 1'b0 || lap_idx_o !== '0 || count_o !== '0 ||
        full_o !== 1'b0 || overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got time=%h br=%b idx=%0d cnt=%0d full=%b ovf=%b, want all zero",
               name, time_o, browse_o, lap_idx_o, count_o, full_o, overflow_o);
    end
  endtask

  // Reset lands between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    capture_i = 1'b0; recall_i = 1'b0; clear_i = 1'b0;
    rst = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    exq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      vectors++;
      if (time_o !== e.t || browse_o !== e.br || int'(lap_idx_o) != e.idx ||
          int'(count_o) != e.cnt || full_o !== e.full || overflow_o !== e.ovf) begin
        miscompares++;
        $display("FAIL cycle@%0t: got time=%h br=%b idx=%0d cnt=%0d full=%b ovf=%b; want time=%h br=%b idx=%0d cnt=%0d full=%b ovf=%b",
                 $time, time_o, browse_o, lap_idx_o, count_o, full_o, overflow_o,
                 e.t, e.br, e.idx, e.cnt, e.full, e.ovf);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 check_zero("power_on_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three laps, then browse through them and back to live.
    step(1, 0, 0, 32'h0000_0105);
    step(1, 0, 0, 32'h0000_0210);
    step(1, 0, 0, 32'h0000_0342);
    idle(2);
    for (int i = 0; i < 4; i++) begin step(0, 1, 0, $urandom); idle(2); end

    // Empty recall is ignored; clear beats a same-cycle capture.
    step(0, 0, 1, $urandom);
    step(0, 1, 0, $urandom); idle(2);
    step(1, 0, 1, 32'h1234_5678); idle(2);

    // Nine captures into eight slots: oldest lost, browse shows 2..9.
    for (int v = 1; v <= 9; v++) step(1, 0, 0, v);
    idle(1);
    for (int i = 0; i < 9; i++) begin step(0, 1, 0, $urandom); idle(1); end

    // Full, browsing lap 3, capture forces live; recall in that cycle too is dropped.
    for (int i = 0; i < 3; i++) step(0, 1, 0, $urandom);
    idle(1);
    step(1, 0, 0, 32'h0000_0A0A); idle(2);
    for (int i = 0; i < 2; i++) step(0, 1, 0, $urandom);
    step(1, 1, 0, 32'h0000_0B0B); idle(2);

    // Not full, browsing lap 1, capture+recall moves to lap 2 and appends.
    step(0, 0, 1, $urandom);
    step(1, 0, 0, 32'h11); step(1, 0, 0, 32'h22); step(1, 0, 0, 32'h33);
    step(0, 1, 0, $urandom); idle(1);
    step(1, 1, 0, 32'h44); idle(2);
    for (int i = 0; i < 3; i++) begin step(0, 1, 0, $urandom); idle(1); end

    // Capture+recall from live when empty and when full.
    step(0, 0, 1, $urandom);
    step(1, 1, 0, 32'h55); idle(2);
    for (int v = 0; v < 8; v++) step(1, 0, 0, 32'h100 + v);
    step(0, 1, 0, $urandom); step(0, 1, 0, $urandom);
    idle(2);

    // Reset mid-browse, then live tracking.
    async_reset();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 60) == 0, $urandom);
      if (i == 1500) async_reset();
    end
    idle(2);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
